pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It turns per-stage stall requests and the MEM-stage exception into per-register enable/flush pairs for PC, IF/ID, ID/EX, EX/MEM and MEM/WB, and drives the PC redirect. It tracks multi-cycle EX operations so EX/MEM can hold and capture its hilo/cnt feedback without losing the instruction already in MEM. It also keeps an exception redirect pending while fetch is busy.

---
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl.sv | 81 ++++++++
 tb/tb_pipe_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall/exception requests into the sequencer,
// per-register enable/flush and PC redirect back out to the datapath.
interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] mem_except_type;
  logic [31:0] cp0_epc;
  logic [4:0]  en;
  logic [4:0]  flush;
  logic        redirect;
  logic [31:0] new_pc;

  modport master (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  mem_except_type, cp0_epc,
    output en, flush, redirect, new_pc
  );

  modport slave (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output mem_except_type, cp0_epc,
    input  en, flush, redirect, new_pc
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stall/exception arbitration into
// per-register enable/flush, plus a PC redirect that survives a busy fetch.
//
// state | meaning
// IDLE  | normal operation, exceptions may be taken
// PEND  | redirect target latched, waiting for fetch to accept it
module pipe_ctrl (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.master  bus
);
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE  = 32'h0000000E;

  typedef enum logic {IDLE, PEND} state_t;

  state_t      state, state_nxt;
  logic        ex_hold, ex_hold_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic [31:0] exc_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ex_hold <= 1'b0;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_nxt;
      ex_hold <= ex_hold_nxt;
      pend_pc <= pend_pc_nxt;
    end
  end

  assign exc_pc = (bus.mem_except_type == ERET_CODE) ? bus.cp0_epc : EXC_VECTOR;

  always_comb begin
    bus.en       = 5'b11111;
    bus.flush    = 5'b00000;
    bus.redirect = 1'b0;
    bus.new_pc   = 32'h0;
    state_nxt    = state;
    ex_hold_nxt  = 1'b0;
    pend_pc_nxt  = pend_pc;

    if (!rst) begin
      bus.en    = 5'b00000;
      bus.flush = 5'b11110;
    end else if (state == IDLE && bus.mem_except_type != 32'h0 && !bus.stallreq_mem) begin
      bus.flush    = 5'b11110;
      bus.redirect = 1'b1;
      bus.new_pc   = exc_pc;
      if (bus.stallreq_if) begin
        // Fetch cannot take the new PC yet; hold it until it can.
        bus.en      = 5'b11110;
        pend_pc_nxt = exc_pc;
        state_nxt   = PEND;
      end
    end else if (state == PEND) begin
      bus.redirect = 1'b1;
      bus.new_pc   = pend_pc;
      bus.flush    = 5'b00010;
      bus.en       = {4'b1111, !bus.stallreq_if};
      if (!bus.stallreq_if)
        state_nxt = IDLE;
    end else if (bus.stallreq_mem) begin
      bus.en    = 5'b10000;
      bus.flush = 5'b10000;
    end else if (bus.stallreq_ex) begin
      // First EX stall cycle lets the instruction in MEM retire; later ones bubble.
      bus.en      = 5'b10000;
      bus.flush   = {ex_hold, 4'b0000};
      ex_hold_nxt = 1'b1;
    end else if (bus.stallreq_id) begin
      bus.en    = 5'b11000;
      bus.flush = 5'b00100;
    end else if (bus.stallreq_if) begin
      bus.en    = 5'b11100;
      bus.flush = 5'b00010;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, stall priority, EX multi-cycle,
// ERET, pending redirect, deferred exception and async reset cases.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [4:0] en, input logic [4:0] flush,
                            input logic redirect, input logic [31:0] new_pc);
    chk({tag, ".en"},       {27'h0, bus.en},       {27'h0, en});
    chk({tag, ".flush"},    {27'h0, bus.flush},    {27'h0, flush});
    chk({tag, ".redirect"}, {31'h0, bus.redirect}, {31'h0, redirect});
    chk({tag, ".new_pc"},   bus.new_pc,            new_pc);
  endtask

  task automatic drive(input logic s_if, input logic s_id, input logic s_ex, input logic s_mem,
                       input logic [31:0] code, input logic [31:0] epc);
    bus.stallreq_if     = s_if;
    bus.stallreq_id     = s_id;
    bus.stallreq_ex     = s_ex;
    bus.stallreq_mem    = s_mem;
    bus.mem_except_type = code;
    bus.cp0_epc         = epc;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with random inputs, across a clock edge
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 32'h1, $urandom);
    expect_out("reset", 5'b00000, 5'b11110, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hE, 32'h12345678);
    expect_out("reset2", 5'b00000, 5'b11110, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("run0", 5'b11111, 5'b00000, 1'b0, 32'h0);
    next_cycle();

    // EX multi-cycle, 3 stall cycles
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("ex1", 5'b10000, 5'b00000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("ex2", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("ex3", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("ex_run", 5'b11111, 5'b00000, 1'b0, 32'h0);
    next_cycle();

    // MEM stall outranks EX; first EX cycle after it retires MEM
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    expect_out("mem1", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    expect_out("mem2", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("mem_ex1", 5'b10000, 5'b00000, 1'b0, 32'h0);
    next_cycle();

    // ID and IF stalls, ID outranks IF
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("id", 5'b11000, 5'b00100, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("if", 5'b11100, 5'b00010, 1'b0, 32'h0);
    next_cycle();

    // ERET with fetch ready, exception outranks EX stall
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'hE, 32'h80001234);
    expect_out("eret", 5'b11111, 5'b11110, 1'b1, 32'h80001234);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80001234);
    expect_out("eret_after", 5'b11111, 5'b00000, 1'b0, 32'h0);
    next_cycle();

    // Pending redirect while fetch busy; stalls ignored in PEND
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h80001234);
    expect_out("pend0", 5'b11110, 5'b11110, 1'b1, 32'hBFC00380);
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    expect_out("pend1", 5'b11110, 5'b00010, 1'b1, 32'hBFC00380);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hE, 32'h0);
    expect_out("pend2", 5'b11110, 5'b00010, 1'b1, 32'hBFC00380);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("pend3", 5'b11111, 5'b00010, 1'b1, 32'hBFC00380);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("pend_idle", 5'b11111, 5'b00000, 1'b0, 32'h0);
    next_cycle();

    // Exception deferred behind a MEM stall
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0);
    expect_out("defer1", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h1, 32'h0);
    expect_out("defer2", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
    expect_out("defer_take", 5'b11111, 5'b11110, 1'b1, 32'hBFC00380);
    next_cycle();

    // Async reset in PEND discards the pending redirect
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
    expect_out("rpend0", 5'b11110, 5'b11110, 1'b1, 32'hBFC00380);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("rpend1", 5'b11110, 5'b00010, 1'b1, 32'hBFC00380);
    rst = 1'b0;
    #1;
    expect_out("rpend_rst", 5'b00000, 5'b11110, 1'b0, 32'h0);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_out("rpend_gone", 5'b11111, 5'b00000, 1'b0, 32'h0);
    next_cycle();

    // Async reset mid-EX-stall clears ex_hold
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("rex1", 5'b10000, 5'b00000, 1'b0, 32'h0);
    next_cycle();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("rex_cleared", 5'b10000, 5'b00000, 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expect_out("rex_hold", 5'b10000, 5'b10000, 1'b0, 32'h0);
    next_cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
